dot_product_engine: RTL and testbench
=====================================

Name: dot_product_engine

Overview:
- Parametrised multiply-accumulate engine that computes the dot product of two VEC_LEN-element vectors.
- Operands arrive one element pair per accepted handshake.
- Successor to the fixed 4-bit/8-element dot-product unit, adding:
  - configurable element, vector and accumulator widths;
  - signed/unsigned mode;
  - valid/ready flow control on input and output;
  - overflow reporting.
- Sits between the operand fetch logic and the result writeback path.

Parameters:
ELEM_W, 4, width of each vector element in bits (>=2)
VEC_LEN, 8, number of element pairs per dot product (>=1)
ACC_W, 16, accumulator/result width in bits (>=2*ELEM_W)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  reset, asynchronous, active-high
start  input  1  begin a new dot product; honoured only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
in_valid  input  1  elem_a/elem_b valid
in_ready  output  1  engine accepts a pair this cycle
elem_a  input  ELEM_W  element of vector A
elem_b  input  ELEM_W  element of vector B
out_valid  output  1  result/overflow valid
out_ready  input  1  downstream accepts result
result  output  ACC_W  dot product
overflow  output  1  sticky accumulation overflow for this vector
busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset values:
  - State = IDLE.
  - Accumulator, count, result = 0.
  - overflow, out_valid, in_ready, busy = 0.
  - Latched mode = 0.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 clears the accumulator, count and overflow, latches signed_mode, and moves to ACCUM next cycle.
- ACCUM:
  - in_ready=1.
  - An element pair is accepted when in_valid & in_ready.
  - On acceptance, product = elem_a*elem_b at 2*ELEM_W bits, signed or unsigned per the latched mode.
  - The product is sign- or zero-extended to ACC_W and added to the accumulator; count increments.
  - Cycles with in_valid=0 leave all state unchanged; the count advances only on accepted pairs.
- Last element (count==VEC_LEN-1 accepted):
  - result <= accumulator + extended product.
  - out_valid <= 1, in_ready <= 0, state -> HOLD.
  - Latency: result is visible the cycle after the last pair is accepted.
- HOLD:
  - result, overflow and out_valid are held stable until out_ready=1.
  - On out_valid & out_ready: out_valid drops next cycle and state -> IDLE.
- start is ignored in ACCUM and HOLD. A new start is accepted only from IDLE, one cycle after the output handshake at the earliest.
- signed_mode changes after start have no effect until the next start.
- Arithmetic wraps modulo 2^ACC_W by default.
- overflow is sticky for the current vector:
  - unsigned mode: set on carry out of bit ACC_W-1;
  - signed mode: set when both addends share a sign and the sum sign differs.
- VEC_LEN=1: a single accepted pair goes straight to HOLD.
- Count register width is clog2(VEC_LEN), minimum 1; no wrap occurs within a vector.
- RESET asserted mid-operation aborts immediately to reset values. A partial vector is discarded and no result is produced.

Optional Feature:
- Macro DOT_PRODUCT_SATURATE_EN.
- When defined, each accumulation that overflows clamps instead of wrapping:
  - unsigned: clamp to 2^ACC_W-1;
  - signed: clamp to 2^(ACC_W-1)-1, or -2^(ACC_W-1) on negative overflow;
  - overflow is still set.
- Subsequent accumulations start from the clamped value.
- When undefined, arithmetic wraps and only the overflow flag is reported.

Test Plan:
1. Unsigned, defaults, start with signed_mode=0, 8 pairs of 15×15, in_valid held high → out_valid one cycle after the 8th pair; result=16'h0708 (1800); overflow=0.
2. Signed, start with signed_mode=1, 8 pairs of elem_a=4'h8 (-8), elem_b=4'h7 (7) → result=16'hFE40 (-448); overflow=0.
3. Backpressure, unsigned, pairs 1..8 × 1 with in_valid low every other cycle, out_ready low 5 cycles after out_valid → result=36 (16'h0024), held stable for all 5 cycles; start pulsed during ACCUM and HOLD is ignored; IDLE entered the cycle after out_ready=1.
4. Overflow, ACC_W=10, unsigned, 8 pairs of 15×15:
   - without macro → result=10'h308 (776), overflow=1;
   - with DOT_PRODUCT_SATURATE_EN → result=10'h3FF, overflow=1.
5. Reset mid-operation: RESET pulsed after 3 accepted pairs → all outputs 0, state IDLE; a new start plus 8 pairs of 2×3 gives result=48 (16'h0030) with no residue from the aborted vector.
6. VEC_LEN=1, unsigned, single pair 9×9 → out_valid the next cycle; result=81 (16'h0051).

Source files
------------

// File: rtl/dot_product_engine.sv
// Multiply-accumulate dot-product engine: VEC_LEN element pairs in, one ACC_W result out.
// Optional macro DOT_PRODUCT_SATURATE_EN clamps on overflow instead of wrapping.
module dot_product_engine #(
    parameter int unsigned ELEM_W  = 4,
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned ACC_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] elem_a,
    input  logic [ELEM_W-1:0] elem_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned CntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(VEC_LEN - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              mode_q, mode_d;
    logic              out_valid_q, out_valid_d;

    logic signed [2*ELEM_W-1:0] prod_s;
    logic [2*ELEM_W-1:0]        prod_u;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           sum;
    logic [ACC_W-1:0]           step_val;
    logic                       carry;
    logic                       step_ovf;

    // One accumulation step: extend the product per the latched mode and add.
    always_comb begin
        prod_s   = (2*ELEM_W)'($signed(elem_a)) * (2*ELEM_W)'($signed(elem_b));
        prod_u   = (2*ELEM_W)'(elem_a) * (2*ELEM_W)'(elem_b);
        prod_ext = mode_q ? ACC_W'(prod_s) : ACC_W'(prod_u);
        {carry, sum} = {1'b0, acc_q} + {1'b0, prod_ext};
        if (mode_q) begin
            step_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            step_ovf = carry;
        end
`ifdef DOT_PRODUCT_SATURATE_EN
        if (step_ovf) begin
            if (mode_q) begin
                // Signed overflow can only go in the direction of the shared operand sign.
                step_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                step_val = '1;
            end
        end else begin
            step_val = sum;
        end
`else
        step_val = sum;
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    mode_d  = signed_mode;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d = step_val;
                    ovf_d = ovf_q | step_ovf;
                    if (cnt_q == LastCnt) begin
                        result_d    = step_val;
                        out_valid_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine: three instances (default, ACC_W=10, VEC_LEN=1)
// share one stimulus stream and are each checked against an integer reference model.
module tb_dot_product_engine;

    localparam int NDUT = 3;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic       start, signed_mode, in_valid, out_ready;
    logic [3:0] elem_a, elem_b;
    logic [NDUT-1:0] rdy, ov, ovf, bsy;
    logic [15:0] res0;
    logic [9:0]  res1;
    logic [15:0] res2;

    dot_product_engine #(.ELEM_W(4), .VEC_LEN(8), .ACC_W(16)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .start(start), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(rdy[0]), .elem_a(elem_a), .elem_b(elem_b),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res0), .overflow(ovf[0]),
        .busy(bsy[0])
    );
    dot_product_engine #(.ELEM_W(4), .VEC_LEN(8), .ACC_W(10)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .start(start), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(rdy[1]), .elem_a(elem_a), .elem_b(elem_b),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res1), .overflow(ovf[1]),
        .busy(bsy[1])
    );
    dot_product_engine #(.ELEM_W(4), .VEC_LEN(1), .ACC_W(16)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .start(start), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(rdy[2]), .elem_a(elem_a), .elem_b(elem_b),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res2), .overflow(ovf[2]),
        .busy(bsy[2])
    );

    function automatic int vec_len(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic int acc_w(input int i);
        return (i == 1) ? 10 : 16;
    endfunction

    function automatic logic [15:0] dut_result(input int i);
        case (i)
            0:       return res0;
            1:       return {6'b0, res1};
            default: return res2;
        endcase
    endfunction

    function automatic longint elem_val(input logic [3:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    // Exact integer add, then range check against the ACC_W number range.
    function automatic longint ref_step(input longint acc, input longint p, input int w,
                                        input bit sgn, output bit o);
        longint m, lo, hi, s;
        m  = longint'(1) << w;
        lo = sgn ? -(m / 2) : 0;
        hi = sgn ? (m / 2 - 1) : (m - 1);
        s  = acc + p;
        o  = (s < lo) || (s > hi);
        if (!o) return s;
`ifdef DOT_PRODUCT_SATURATE_EN
        return (s > hi) ? hi : lo;
`else
        s = s % m;
        if (s < 0) s = s + m;
        if (sgn && s > hi) s = s - m;
        return s;
`endif
    endfunction

    typedef struct packed {
        logic [15:0] val;
        logic        ovf;
    } exp_t;

    exp_t   sb [NDUT][$];
    int     m_st  [NDUT];   // 0 idle, 1 accumulating, 2 holding a result
    longint m_acc [NDUT];
    int     m_cnt [NDUT];
    bit     m_ovf [NDUT];
    bit     m_mode[NDUT];

    int n_tests = 0;
    int n_fail  = 0;
    int n_tmo   = 0;
    int tmo_seen = 0;
    longint p;
    bit     o;
    exp_t   e;

    task automatic chk(input string name, input int i, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, i, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the model, then advance the model with this cycle's inputs.
    always @(negedge CLK) begin
        if (n_tmo != tmo_seen) begin
            chk("driver_timeout", 0, longint'(n_tmo), longint'(tmo_seen));
            tmo_seen = n_tmo;
        end
        for (int i = 0; i < NDUT; i++) begin
            if (RESET) begin
                chk("reset_in_ready", i, longint'(rdy[i]), 0);
                chk("reset_out_valid", i, longint'(ov[i]), 0);
                chk("reset_busy", i, longint'(bsy[i]), 0);
                chk("reset_overflow", i, longint'(ovf[i]), 0);
                chk("reset_result", i, longint'(dut_result(i)), 0);
                m_st[i] = 0;
                sb[i].delete();
            end else begin
                chk("in_ready", i, longint'(rdy[i]), longint'(m_st[i] == 1));
                chk("busy", i, longint'(bsy[i]), longint'(m_st[i] != 0));
                chk("out_valid", i, longint'(ov[i]), longint'(m_st[i] == 2));
                if (m_st[i] == 2) begin
                    if (sb[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard_empty dut%0d: got result %0h, expected none",
                                 i, dut_result(i));
                    end else begin
                        e = sb[i][0];
                        chk("result", i, longint'(dut_result(i)), longint'(e.val));
                        chk("overflow", i, longint'(ovf[i]), longint'(e.ovf));
                    end
                end
                case (m_st[i])
                    0: if (start) begin
                        m_acc[i]  = 0;
                        m_cnt[i]  = 0;
                        m_ovf[i]  = 1'b0;
                        m_mode[i] = signed_mode;
                        m_st[i]   = 1;
                    end
                    1: if (in_valid) begin
                        p = elem_val(elem_a, m_mode[i]) * elem_val(elem_b, m_mode[i]);
                        m_acc[i] = ref_step(m_acc[i], p, acc_w(i), m_mode[i], o);
                        m_ovf[i] = m_ovf[i] | o;
                        m_cnt[i]++;
                        if (m_cnt[i] == vec_len(i)) begin
                            e.val = 16'(m_acc[i] & ((longint'(1) << acc_w(i)) - 1));
                            e.ovf = m_ovf[i];
                            sb[i].push_back(e);
                            m_st[i] = 2;
                        end
                    end
                    default: if (out_ready) begin
                        void'(sb[i].pop_front());
                        m_st[i] = 0;
                    end
                endcase
            end
        end
    end

    logic [3:0] va [8];
    logic [3:0] vb [8];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // gap: 0 = in_valid always high, 1 = every other cycle, 2 = random ~30% idle
    task automatic run_vec(input bit mode, input int gap, input int hold, input bit poke);
        int  got = 0;
        int  budget = 0;
        bit  acc_now;
        start       = 1'b1;
        signed_mode = mode;
        step();
        start       = 1'b0;
        signed_mode = 1'($urandom);
        while (got < 8 && budget < 200) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = budget[0];
                default: in_valid = ($urandom_range(99) >= 30);
            endcase
            elem_a  = va[got];
            elem_b  = vb[got];
            start   = poke && ($urandom_range(2) == 0);
            acc_now = in_valid & rdy[0];
            step();
            if (acc_now) got++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (got < 8) n_tmo++;
        budget = 0;
        while (!ov[0] && budget < 20) begin
            step();
            budget++;
        end
        if (!ov[0]) n_tmo++;
        repeat (hold) begin
            start = poke;
            step();
        end
        out_ready = 1'b1;
        start     = poke;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic fill(input logic [3:0] a, input logic [3:0] b);
        for (int k = 0; k < 8; k++) begin
            va[k] = a;
            vb[k] = b;
        end
    endtask

    initial begin
        int  got;
        bit  acc_now;
        RESET = 1'b1; start = 1'b0; signed_mode = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; elem_a = '0; elem_b = '0;
        repeat (3) step();
        RESET = 1'b0;
        step();

        // Unsigned 15x15 (also wraps/saturates the 10-bit instance)
        fill(4'hF, 4'hF);
        run_vec(1'b0, 0, 0, 1'b0);
        // Signed -8 x 7
        fill(4'h8, 4'h7);
        run_vec(1'b1, 0, 0, 1'b0);
        // Backpressure: 1..8 x 1, alternating in_valid, 5 held cycles, start pokes ignored
        for (int k = 0; k < 8; k++) begin
            va[k] = 4'(k + 1);
            vb[k] = 4'd1;
        end
        run_vec(1'b0, 1, 5, 1'b1);
        // Single 9x9 pair leads the vector
        fill(4'h9, 4'h9);
        run_vec(1'b0, 0, 1, 1'b0);

        // Abort after 3 accepted pairs
        fill(4'hF, 4'hF);
        start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        in_valid = 1'b1;
        while (got < 3) begin
            acc_now = rdy[0];
            step();
            if (acc_now) got++;
        end
        in_valid = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        step();
        fill(4'h2, 4'h3);
        run_vec(1'b0, 0, 0, 1'b0);

        // Random vectors in both modes
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < 8; k++) begin
                va[k] = 4'($urandom);
                vb[k] = 4'($urandom);
            end
            run_vec(1'($urandom), 2, $urandom_range(3), 1'($urandom));
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
